// File: rtl/xs3_pkg.sv
// Shared types and constants for the BCD to Excess-3 sequencer.
package xs3_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] XS3_OFFSET  = 4'h3;
  localparam logic [3:0] BCD_MAX     = 4'h9;
  localparam logic [3:0] XS3_INVALID = 4'h0;
endpackage

// File: rtl/xs3_digit_conv.sv
// Single-digit BCD to Excess-3 converter, purely combinational.
module xs3_digit_conv
  import xs3_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [3:0] xs3_o,
  output logic       invalid_o
);
  assign invalid_o = (bcd_i > BCD_MAX);
  assign xs3_o     = invalid_o ? XS3_INVALID : 4'(bcd_i + XS3_OFFSET);
endmodule

// File: rtl/bcd_xs3_seq_ctrl.sv
// Multi-digit BCD to Excess-3 sequencer: one shared converter, LSD first.
// Optional sticky invalid-digit flag on out_err when BCD_XS3_ERR_EN is defined.
module bcd_xs3_seq_ctrl
  import xs3_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_xs3,
  output logic                  busy
`ifdef BCD_XS3_ERR_EN
  ,
  output logic                  out_err
`endif
);
  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     shift_q, shift_d;
  logic [W-1:0]     xs3_q, xs3_d;
  logic [3:0]       dig_xs3;
  logic             dig_inv;

  xs3_digit_conv u_conv (
    .bcd_i     (shift_q[3:0]),
    .xs3_o     (dig_xs3),
    .invalid_o (dig_inv)
  );

  // in_ready is masked by reset so it reads 0 while rst_n is held low.
  assign in_ready  = rst_n & (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CONV) | (state_q == DONE);
  assign out_xs3   = xs3_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    xs3_d   = xs3_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = in_bcd;
          idx_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        xs3_d[idx_q*4 +: 4] = dig_xs3;
        shift_d = shift_q >> 4;
        if (idx_q == LAST_IDX) state_d = DONE;
        else                   idx_d   = idx_q + 1'b1;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      xs3_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      xs3_q   <= xs3_d;
    end
  end

`ifdef BCD_XS3_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && in_valid) err_d = 1'b0;
    else if (state_q == CONV)        err_d = err_q | dig_inv;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign out_err = err_q;
`else
  logic unused_dig_inv;
  assign unused_dig_inv = dig_inv;
`endif
endmodule

// File: tb/tb_bcd_xs3_seq_ctrl.sv
// Scoreboard bench for bcd_xs3_seq_ctrl: random and directed words vs a digit-wise model.
module tb_bcd_xs3_seq_ctrl;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] in_bcd = '0;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] out_xs3;
`ifdef BCD_XS3_ERR_EN
  logic         out_err;
`endif

  bcd_xs3_seq_ctrl #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcd    (in_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_xs3   (out_xs3),
    .busy      (busy)
`ifdef BCD_XS3_ERR_EN
    ,
    .out_err   (out_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] xs3;
    logic         err;
    int           t_acc;
  } exp_t;

  exp_t sb[$];
  int   acc_cyc[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   rnd_rdy = 0;
  bit   exp_ov;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: each digit independently, value+3 if 0..9, else 0 and flagged.
  function automatic exp_t model(input logic [W-1:0] w, input int t);
    exp_t r;
    int   d;
    r.xs3 = '0;
    r.err = 1'b0;
    r.t_acc = t;
    for (int k = 0; k < DIGITS; k++) begin
      d = int'(w[4*k +: 4]);
      if (d <= 9) r.xs3[4*k +: 4] = 4'(d + 3);
      else        r.err = 1'b1;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      exp_ov = (sb.size() > 0) && (cyc >= sb[0].t_acc + DIGITS + 1);
      check("in_ready", in_ready, sb.size() == 0);
      check("busy", busy, sb.size() != 0);
      check("out_valid", out_valid, exp_ov);
      if (out_valid && sb.size() > 0) begin
        check("out_xs3", out_xs3, sb[0].xs3);
`ifdef BCD_XS3_ERR_EN
        check("out_err", out_err, sb[0].err);
`endif
        if (out_ready) void'(sb.pop_front());
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_bcd, cyc));
        acc_cyc.push_back(cyc);
      end
    end
  end

  always @(posedge clk) if (rnd_rdy) #1 out_ready = ($urandom_range(0, 3) != 0);

  task automatic send(input logic [W-1:0] w);
    @(posedge clk);
    #1 in_valid = 1'b1;
    in_bcd = w;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL send_timeout: in_ready never rose for word %0h", w);
  endtask

  task automatic idle();
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL drain_timeout: %0d results still pending", sb.size());
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] w;
    for (int k = 0; k < DIGITS; k++)
      w[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                 : 4'($urandom_range(0, 9));
    return w;
  endfunction

  task automatic reset_checks(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_xs3"}, out_xs3, 0);
    check({tag, "_busy"}, busy, 0);
`ifdef BCD_XS3_ERR_EN
    check({tag, "_out_err"}, out_err, 0);
`endif
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_checks("rst");
    #1 rst_n = 1'b1;

    // directed words
    send(16'h1234); idle();
    send(16'h0999); idle();
    send(16'h9000); idle();
    send(16'h12A4); idle();
    send(16'h0000); idle();
    drain();

    // stall in DONE for 5 cycles
    out_ready = 1'b0;
    send(16'h4321); idle();
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #2;
      if (out_valid) break;
    end
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // async reset during the second CONV cycle
    send(16'h1234);
    idle();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 reset_checks("midrst");
    sb.delete();
    acc_cyc.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    send(16'h5678); idle();
    drain();

    // back-to-back with in_valid held high
    acc_cyc.delete();
    for (int i = 0; i < 4; i++) send(rnd_word());
    idle();
    drain();
    check("burst_count", acc_cyc.size(), 4);
    for (int i = 1; i < acc_cyc.size(); i++)
      check("burst_period", acc_cyc[i] - acc_cyc[i-1], DIGITS + 2);

    // random traffic with random sink stalls
    rnd_rdy = 1;
    for (int n = 0; n < 40; n++) begin
      send(rnd_word());
      if ($urandom_range(0, 1) != 0) begin
        idle();
        repeat ($urandom_range(0, 6)) @(posedge clk);
      end
    end
    idle();
    rnd_rdy = 0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bcd_xs3_seq_ctrl.md
Name: bcd_xs3_seq_ctrl

Overview:
- Sequencer that converts a packed multi-digit BCD word to packed Excess-3 (digit + 3) using one shared single-digit converter.
- Accepts a word through a valid/ready handshake and feeds the converter one digit per cycle, least-significant digit first.
- Assembles the result in a register and presents it through a valid/ready handshake.
- Sits between a BCD source (keypad/counter front end) and display or serial-encode logic.

Parameters:
- DIGITS, 4, number of BCD digits per word. Legal range 1..16.
- IDX_W, derived as max(1, $clog2(DIGITS)), width of the digit index counter. Not user-set.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  source has a word.
- in_ready  out  1  block can accept a word.
- in_bcd  in  4*DIGITS  packed BCD; digit k occupies bits [4k+3:4k].
- out_valid  out  1  result word available.
- out_ready  in  1  sink accepts the result.
- out_xs3  out  4*DIGITS  packed Excess-3 result, same digit layout as in_bcd.
- busy  out  1  high in CONV or DONE.
- out_err  out  1  only present with BCD_XS3_ERR_EN; at least one input digit was greater than 9.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_xs3=0, busy=0, out_err=0, idx=0, state=IDLE. Reset is asynchronous and forces all of these in any state, including mid-conversion; the partial word is discarded.
- First cycle after reset release: state is IDLE, so in_ready=1.
- Outputs: in_ready, out_valid and busy are decoded from the state register only. out_xs3 and out_err are registers.
- State IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch in_bcd into a shift register, clear idx and the error flag, then go to CONV.
- State CONV (one digit per cycle):
  - The converter is driven by shift_reg[3:0].
  - Its result is written into out_xs3 digit slot idx; the shift register shifts right by 4; idx increments.
  - When idx==DIGITS-1, that digit is written and the next state is DONE.
  - CONV lasts exactly DIGITS cycles. in_valid is ignored during CONV.
- State DONE:
  - out_valid=1. out_xs3 and out_err are held stable until out_valid&out_ready.
  - On that handshake, go to IDLE.
  - Back-to-back acceptance in the same cycle is not allowed: the next input is accepted at the earliest one cycle later.
- Latency: input handshake at cycle t, out_valid asserted at cycle t+DIGITS+1. Minimum period is DIGITS+2 cycles per word.
- Converter rule (combinational, 4-bit):
  - Digits 0..9 give digit+3 (0x3..0xC).
  - Digits 0xA..0xF give 4'h0 and are flagged invalid.
  - Arithmetic is 4-bit; no carry between digits.
- DIGITS=1: CONV lasts 1 cycle; idx stays 0.
- Stalls: out_ready held low holds the block in DONE indefinitely, with in_ready=0.
- in_valid asserted in DONE is not accepted; the source holds its data until in_ready.
- Protocol rules: in_bcd is sampled only on the input handshake. The source must not drop in_valid before in_ready (not checked by the RTL).

Optional Feature:
- Macro BCD_XS3_ERR_EN.
- Defined:
  - The out_err port exists.
  - A sticky flag ORs the converter's invalid indication over all digits of the word. It is cleared on input accept and presented with out_xs3 in DONE.
- Undefined:
  - The port and the flag are absent.
  - Invalid digits silently produce 4'h0 in their slot.
  - Timing is identical either way.

Decomposition:
- Package xs3_pkg holds:
  - state enum {IDLE, CONV, DONE}, 2 bits;
  - localparam XS3_OFFSET=4'h3;
  - localparam BCD_MAX=4'h9;
  - localparam XS3_INVALID=4'h0.
- Sub-module xs3_digit_conv: 4-bit in; 4-bit out plus an invalid bit; purely combinational. It is instantiated once in bcd_xs3_seq_ctrl and shared across all digits.

Test Plan:
- Reset, then DIGITS=4, in_bcd=16'h1234 accepted at cycle t → out_valid at t+5, out_xs3=16'h4567, out_err=0.
- in_bcd=16'h0999 → out_xs3=16'h3CCC. in_bcd=16'h9000 → 16'hC333.
- With BCD_XS3_ERR_EN, in_bcd=16'h12A4 → out_xs3=16'h4507, out_err=1. The next word 16'h0000 → 16'h3333 with out_err=0 (the flag has cleared).
- Hold out_ready=0 for 5 cycles in DONE → out_xs3 stable, in_ready=0, busy=1. Raise out_ready → IDLE next cycle, in_ready=1.
- Assert rst_n=0 asynchronously during the 2nd CONV cycle → all outputs 0 immediately. After release, 16'h5678 → 16'h89AB with correct latency.
- Keep in_valid high continuously with 4 words → each accepted one cycle after the previous out handshake, with a period of 6 cycles when out_ready=1.
